// File: rtl/instr_decode_fsm_if.sv
// instr_decode_fsm_if: instruction handshake between fetch side and the decoder
interface instr_decode_fsm_if;
    logic [15:0] instr_in;
    logic        instr_valid_in;
    logic        instr_ready_out;
    modport master (output instr_in, output instr_valid_in, input instr_ready_out);
    modport slave (input instr_in, input instr_valid_in, output instr_ready_out);
endinterface

// File: rtl/instr_decode_fsm.sv
// instr_decode_fsm: LC-3 subset decoder FSM (BR/ADD/AND/NOT); optional ILLEGAL_OP_TRAP_EN adds TRAP state and illegal_out
module instr_decode_fsm (
    input  logic        clka,
    input  logic        reset_n_in,
    instr_decode_fsm_if.slave bus,
    output logic        n_dec_out,
    output logic        z_dec_out,
    output logic        p_dec_out,
    output logic        br_out,
    output logic        we_reg_out,
    output logic [1:0]  alu_op_out,
    output logic [2:0]  dr_out,
    output logic [2:0]  sr1_out,
    output logic [2:0]  sr2_out,
    output logic [15:0] imm5_out,
    output logic        imm_sel_out,
`ifdef ILLEGAL_OP_TRAP_EN
    output logic        illegal_out,
`endif
    output logic [2:0]  state_out
);
    localparam logic [2:0] IDLE = 3'd0, DECODE = 3'd1, EXEC = 3'd2, WB = 3'd3;
`ifdef ILLEGAL_OP_TRAP_EN
    localparam logic [2:0] TRAP = 3'd4;
`endif
    logic [2:0]  state_q, state_d;
    logic [15:0] ir_q;
    logic [3:0]  op;
    logic        is_br, is_alu;
    logic        n_q, z_q, p_q, imm_sel_q, n_d, z_d, p_d, imm_sel_d;
    logic [1:0]  alu_q, alu_d;
    logic [2:0]  dr_q, sr1_q, sr2_q;
    logic [15:0] imm5_q, imm5_d;

    assign op     = ir_q[15:12];
    assign is_br  = op == 4'b0000;
    assign is_alu = op == 4'b0001 || op == 4'b0101 || op == 4'b1001;

    // state register; IR captured on acceptance, decoded fields captured leaving DECODE
    always_ff @(posedge clka or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q   <= IDLE;
            ir_q      <= '0;
            {n_q, z_q, p_q, imm_sel_q} <= '0;
            alu_q     <= '0;
            {dr_q, sr1_q, sr2_q} <= '0;
            imm5_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.instr_valid_in)
                ir_q <= bus.instr_in;
            if (state_q == DECODE) begin
                {n_q, z_q, p_q} <= {n_d, z_d, p_d};
                imm_sel_q <= imm_sel_d;
                alu_q     <= alu_d;
                dr_q      <= ir_q[11:9];
                sr1_q     <= ir_q[8:6];
                sr2_q     <= ir_q[2:0];
                imm5_q    <= imm5_d;
            end
        end
    end

    // next-state: BR and unknown opcodes finish in EXEC, ALU ops write back
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.instr_valid_in ? DECODE : IDLE;
            DECODE:  state_d = EXEC;
`ifdef ILLEGAL_OP_TRAP_EN
            EXEC:    state_d = is_br ? IDLE : is_alu ? WB : TRAP;
            TRAP:    state_d = TRAP;
`else
            EXEC:    state_d = is_alu ? WB : IDLE;
`endif
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // field decode from IR plus state-driven handshake and pulse outputs
    always_comb begin
        {n_d, z_d, p_d} = is_br ? ir_q[11:9] : 3'b000;
        alu_d       = op == 4'b0001 ? 2'b00 : op == 4'b0101 ? 2'b01 : op == 4'b1001 ? 2'b10 : 2'b11;
        imm_sel_d   = (op == 4'b0001 || op == 4'b0101) && ir_q[5];
        imm5_d      = {{11{ir_q[4]}}, ir_q[4:0]};
        bus.instr_ready_out = state_q == IDLE;
        br_out      = state_q == EXEC && is_br;
        we_reg_out  = state_q == WB;
`ifdef ILLEGAL_OP_TRAP_EN
        illegal_out = state_q == TRAP;
`endif
        state_out   = state_q;
        {n_dec_out, z_dec_out, p_dec_out} = {n_q, z_q, p_q};
        alu_op_out  = alu_q;
        dr_out      = dr_q;
        sr1_out     = sr1_q;
        sr2_out     = sr2_q;
        imm5_out    = imm5_q;
        imm_sel_out = imm_sel_q;
    end
endmodule

// File: tb/tb_instr_decode_fsm.sv
// tb_instr_decode_fsm: directed checks of instr_decode_fsm (build with ILLEGAL_OP_TRAP_EN to cover TRAP)
module tb_instr_decode_fsm;
    logic        clka = 0;
    logic        reset_n_in = 0;
    logic        n_dec_out, z_dec_out, p_dec_out, br_out, we_reg_out, imm_sel_out;
    logic [1:0]  alu_op_out;
    logic [2:0]  dr_out, sr1_out, sr2_out, state_out;
    logic [15:0] imm5_out;
`ifdef ILLEGAL_OP_TRAP_EN
    logic        illegal_out;
`endif
    int total = 0, bad = 0;

    instr_decode_fsm_if bus ();

    instr_decode_fsm dut (
        .clka(clka), .reset_n_in(reset_n_in), .bus(bus),
        .n_dec_out(n_dec_out), .z_dec_out(z_dec_out), .p_dec_out(p_dec_out),
        .br_out(br_out), .we_reg_out(we_reg_out), .alu_op_out(alu_op_out),
        .dr_out(dr_out), .sr1_out(sr1_out), .sr2_out(sr2_out),
        .imm5_out(imm5_out), .imm_sel_out(imm_sel_out),
`ifdef ILLEGAL_OP_TRAP_EN
        .illegal_out(illegal_out),
`endif
        .state_out(state_out)
    );

    always #5 clka = ~clka;

    initial begin
        #100000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // waits for ready, presents one instruction for a single edge T, returns at the negedge after T
    task automatic send(input logic [15:0] w);
        int n = 0;
        while (bus.instr_ready_out !== 1'b1 && n < 20) begin
            @(negedge clka);
            n++;
        end
        if (n >= 20) chk("ready_wait", 0, 1);
        bus.instr_in = w;
        bus.instr_valid_in = 1;
        @(posedge clka);
        #1 bus.instr_valid_in = 0;
        @(negedge clka);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_state"}, state_out, 0);
        chk({tag, "_ready"}, bus.instr_ready_out, 1);
        chk({tag, "_fields"}, {n_dec_out, z_dec_out, p_dec_out, br_out, we_reg_out, alu_op_out,
                               dr_out, sr1_out, sr2_out, imm_sel_out}, 0);
        chk({tag, "_imm5"}, imm5_out, 0);
    endtask

    initial begin
        int pulses;
        bus.instr_in = 0;
        bus.instr_valid_in = 0;
        #1 chk_idle_outputs("rst");
        repeat (2) @(negedge clka);
        reset_n_in = 1;
        @(negedge clka);
        chk("idle_hold", state_out, 0);

        // ADD register form
        send(16'h1283);
        chk("add_dec_state", state_out, 1);
        chk("add_dec_ready", bus.instr_ready_out, 0);
        @(negedge clka);
        chk("add_exec_state", state_out, 2);
        chk("add_alu", alu_op_out, 2'b00);
        chk("add_regs", {dr_out, sr1_out, sr2_out}, {3'd1, 3'd2, 3'd3});
        chk("add_imm_sel", imm_sel_out, 0);
        chk("add_exec_we", we_reg_out, 0);
        chk("add_exec_br", br_out, 0);
        @(negedge clka);
        chk("add_wb_state", state_out, 3);
        chk("add_wb_we", we_reg_out, 1);
        @(negedge clka);
        chk("add_done_state", state_out, 0);
        chk("add_done_we", we_reg_out, 0);
        chk("add_done_ready", bus.instr_ready_out, 1);

        // ADD immediate form
        send(16'h127F);
        pulses = (we_reg_out === 1'b1) ? 1 : 0;
        @(negedge clka);
        chk("addi_imm_sel", imm_sel_out, 1);
        chk("addi_imm5", imm5_out, 16'hFFFF);
        chk("addi_regs", {dr_out, sr1_out}, {3'd1, 3'd1});
        for (int i = 0; i < 4; i++) begin
            if (we_reg_out === 1'b1) pulses++;
            @(negedge clka);
        end
        chk("addi_we_pulses", pulses, 1);

        // BR nz
        send(16'h0C05);
        chk("br_dec_br", br_out, 0);
        @(negedge clka);
        chk("br_nzp", {n_dec_out, z_dec_out, p_dec_out}, 3'b110);
        chk("br_pulse", br_out, 1);
        chk("br_we", we_reg_out, 0);
        chk("br_alu", alu_op_out, 2'b11);
        @(negedge clka);
        chk("br_done_state", state_out, 0);
        chk("br_done_ready", bus.instr_ready_out, 1);
        chk("br_done_pulses", {br_out, we_reg_out}, 0);

        // NOT with valid held high: next acceptance only at T+4
        bus.instr_in = 16'h997F;
        bus.instr_valid_in = 1;
        @(posedge clka);
        @(negedge clka);
        chk("not_t0_state", state_out, 1);
        @(negedge clka);
        chk("not_t1_state", state_out, 2);
        chk("not_alu", alu_op_out, 2'b10);
        chk("not_regs", {dr_out, sr1_out}, {3'd4, 3'd5});
        chk("not_nzp", {n_dec_out, z_dec_out, p_dec_out}, 0);
        chk("not_imm_sel", imm_sel_out, 0);
        @(negedge clka);
        chk("not_t2_state", state_out, 3);
        @(negedge clka);
        chk("not_t3_state", state_out, 0);
        @(negedge clka);
        chk("not_t4_state", state_out, 1);
        bus.instr_valid_in = 0;
        repeat (3) @(negedge clka);
        chk("not_drain_state", state_out, 0);

        // asynchronous reset mid-DECODE
        send(16'h1283);
        chk("rst_pre_state", state_out, 1);
        #2 reset_n_in = 0;
        #1 chk_idle_outputs("rst_async");
        @(negedge clka);
        reset_n_in = 1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            if (br_out === 1'b1 || we_reg_out === 1'b1 || state_out !== 3'd0) pulses++;
            @(negedge clka);
        end
        chk("rst_no_resume", pulses, 0);

        // illegal opcode
        send(16'hF025);
        @(negedge clka);
        chk("ill_exec_state", state_out, 2);
        chk("ill_alu", alu_op_out, 2'b11);
        chk("ill_exec_pulses", {br_out, we_reg_out}, 0);
        @(negedge clka);
`ifdef ILLEGAL_OP_TRAP_EN
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            if (state_out !== 3'd4 || illegal_out !== 1'b1 || bus.instr_ready_out !== 1'b0 ||
                br_out !== 1'b0 || we_reg_out !== 1'b0) pulses++;
            bus.instr_valid_in = 1;
            @(negedge clka);
        end
        bus.instr_valid_in = 0;
        chk("trap_hold", pulses, 0);
        reset_n_in = 0;
        #1 chk("trap_rst_illegal", illegal_out, 0);
        chk_idle_outputs("trap_rst");
        @(negedge clka);
        reset_n_in = 1;
`else
        chk("ill_done_state", state_out, 0);
        chk("ill_done_pulses", {br_out, we_reg_out}, 0);
        chk("ill_done_ready", bus.instr_ready_out, 1);
`endif

        // normal operation after all of the above
        send(16'h5283);
        @(negedge clka);
        chk("and_alu", alu_op_out, 2'b01);
        @(negedge clka);
        chk("and_we", we_reg_out, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_decode_fsm.md
INSTR_DECODE_FSM -- requirements
Module: instr_decode_fsm

Interface
REQ-001 SHALL have port clka, input, 1 bit: single system clock, rising-edge active.
REQ-002 SHALL have port reset_n_in, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port instr_in, input, 16 bits: instruction word (LC-3 encoding).
REQ-004 SHALL have port instr_valid_in, input, 1 bit: instr_in valid this cycle.
REQ-005 SHALL have port instr_ready_out, output, 1 bit: block accepts an instruction this cycle.
REQ-006 SHALL have ports n_dec_out, z_dec_out and p_dec_out, outputs, 1 bit each: BR condition bits IR[11], IR[10], IR[9]; these feed the ALU FSM n_dec_in/z_dec_in/p_dec_in.
REQ-007 SHALL have port br_out, output, 1 bit: branch-evaluate pulse to the ALU FSM br_in.
REQ-008 SHALL have port we_reg_out, output, 1 bit: register-write pulse to the ALU FSM we_reg_in and the register file.
REQ-009 SHALL have port alu_op_out, output, 2 bits: ALU operation, 00 ADD, 01 AND, 10 NOT, 11 PASS.
REQ-010 SHALL have ports dr_out, sr1_out and sr2_out, outputs, 3 bits each: IR[11:9], IR[8:6], IR[2:0].
REQ-011 SHALL have port imm5_out, output, 16 bits: IR[4:0] sign-extended to 16 bits.
REQ-012 SHALL have port imm_sel_out, output, 1 bit: IR[5] for ADD/AND; 0 otherwise.
REQ-013 SHALL have port state_out, output, 3 bits: current FSM state encoding.

Function
REQ-014 SHALL implement states IDLE=0, DECODE=1, EXEC=2, WB=3 and TRAP=4; TRAP is used only when ILLEGAL_OP_TRAP_EN is defined.
REQ-015 SHALL assert instr_ready_out only in IDLE.
REQ-016 SHALL latch instr_in into an internal 16-bit IR, and go IDLE->DECODE, on a rising edge with instr_valid_in=1 in IDLE; with instr_valid_in=0 it SHALL stay in IDLE.
REQ-017 SHALL register all field outputs (REQ-006, REQ-009 to REQ-012) from IR on the DECODE->EXEC edge and hold them stable until the next DECODE->EXEC edge.
REQ-018 SHALL treat the legal opcodes as BR 0000, ADD 0001, AND 0101 and NOT 1001.
REQ-019 SHALL force n_dec_out, z_dec_out and p_dec_out to 0 for non-BR opcodes.
REQ-020 SHALL set alu_op_out to 11 (PASS) for BR and illegal opcodes.
REQ-021 SHALL go EXEC->IDLE for BR, and SHALL assert br_out for exactly the EXEC cycle.
REQ-022 SHALL go EXEC->WB for ADD, AND and NOT, and then WB->IDLE.
REQ-023 SHALL assert we_reg_out for exactly the WB cycle.
REQ-024 SHALL give the following latency, with acceptance at edge T:
- fields valid after T+1;
- br_out high in cycle T+2 (BR);
- we_reg_out high in cycle T+3 (ALU ops);
- instr_ready_out high again after T+2 (BR) or T+3 (ALU ops).
REQ-025 SHALL ignore instr_valid_in in every state except IDLE; no instruction is buffered.
REQ-026 SHALL never assert br_out and we_reg_out in the same cycle.
REQ-027 SHALL, for an illegal opcode without ILLEGAL_OP_TRAP_EN, go EXEC->IDLE with no br_out and no we_reg_out (NOP).

Reset
REQ-028 SHALL, while reset_n_in=0, immediately and independently of clka:
- force state IDLE;
- clear IR;
- clear every output (all 0) except instr_ready_out=1.
REQ-029 SHALL abort any in-flight instruction on reset asserted mid-operation, with no br_out or we_reg_out pulse emitted afterwards.
REQ-030 SHALL resume normal operation on the first rising clka after reset_n_in returns to 1.

Configuration
REQ-031 SHALL, with ILLEGAL_OP_TRAP_EN defined, route an illegal opcode EXEC->TRAP and add output illegal_out (1 bit).
REQ-032 SHALL, with ILLEGAL_OP_TRAP_EN defined, set illegal_out to 1 on entry to TRAP.
REQ-033 SHALL, with ILLEGAL_OP_TRAP_EN defined, hold TRAP with instr_ready_out=0, illegal_out=1 and no br_out or we_reg_out until reset_n_in=0.
REQ-034 SHALL, without ILLEGAL_OP_TRAP_EN, omit the TRAP state and the illegal_out port and apply REQ-027.

Verification
REQ-035 SHALL cover reset: reset_n_in=0 asserted mid-DECODE -> state_out=0, instr_ready_out=1, all other outputs 0, with no clock edge needed.
REQ-036 SHALL cover ADD register form: instr_in=0x1283 -> alu_op_out=00, dr_out=1, sr1_out=2, sr2_out=3, imm_sel_out=0; we_reg_out pulses in cycle T+3 only.
REQ-037 SHALL cover ADD immediate form: instr_in=0x127F -> imm_sel_out=1, imm5_out=0xFFFF, dr_out=1, sr1_out=1; we_reg_out pulses once.
REQ-038 SHALL cover BR: instr_in=0x0C05 -> n_dec_out=1, z_dec_out=1, p_dec_out=0; br_out pulses in cycle T+2; we_reg_out stays 0; instr_ready_out=1 after T+2.
REQ-039 SHALL cover NOT with back-to-back valid: instr_in=0x997F with instr_valid_in held at 1 -> alu_op_out=10, dr_out=4, sr1_out=5; next acceptance at T+4, not earlier.
REQ-040 SHALL cover an illegal opcode: instr_in=0xF025 -> with the macro, state_out=4 and illegal_out=1 until reset; without the macro, a NOP with no pulses and a return to IDLE.
